// File: rtl/out_pkg.sv
// Shared constants and types for the OUT display stage: slot geometry,
// active-low 7-segment codes ({dp,g,f,e,d,c,b,a}) and the digit index type.
package out_pkg;

  localparam int OUT_SLOTS = 8;
  localparam int OUT_SEL_W = 3;
  localparam int OUT_VAL_W = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/out_display_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder; dp is held off.
module hex_to_seg
  import out_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/out_display.sv
// OUT command capture into 8 slots plus a 4-digit multiplexed hex display.
// Define OUT_DISPLAY_LZB_EN to blank leading zero digits (digit 0 always shown).
module out_display
  import out_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 out_valid,
  input  logic [OUT_SEL_W-1:0] outsel,
  input  logic [OUT_VAL_W-1:0] outval,
  input  logic [OUT_SEL_W-1:0] view_sel,
  output logic [7:0]           seg,
  output logic [3:0]           an,
  output logic [OUT_SLOTS-1:0] written
);

  if (NUM_DIGITS != 4 || SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_param
    $error("out_display: NUM_DIGITS must be 4 and SCAN_DIV within 2..65535");
  end

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [OUT_VAL_W-1:0] slot_q [OUT_SLOTS];
  logic [OUT_SLOTS-1:0] written_q;
  logic [15:0]          scan_cnt_q, scan_cnt_d;
  digit_idx_t           digit_q, digit_d;
  logic [7:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;

  logic [OUT_VAL_W-1:0] view_val;
  logic [3:0]           nibble;
  logic [7:0]           hex_seg;

  assign view_val = slot_q[view_sel];

  always_comb begin
    nibble = view_val[3:0];
    case (digit_q)
      2'd0: nibble = view_val[3:0];
      2'd1: nibble = view_val[7:4];
      2'd2: nibble = view_val[11:8];
      2'd3: nibble = view_val[15:12];
      default: nibble = view_val[3:0];
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_o    (hex_seg)
  );

`ifdef OUT_DISPLAY_LZB_EN
  // A digit is blank when it and every digit above it are zero.
  logic blank;
  always_comb begin
    blank = 1'b0;
    case (digit_q)
      2'd1: blank = (view_val[15:4] == 12'h000);
      2'd2: blank = (view_val[15:8] == 8'h00);
      2'd3: blank = (view_val[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
  assign seg_d = blank ? SEG_BLANK : hex_seg;
`else
  assign seg_d = hex_seg;
`endif

  assign an_d = ~(4'b0001 << digit_q);

  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 16'd0;
      digit_d    = digit_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < OUT_SLOTS; i++) slot_q[i] <= '0;
      written_q  <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'b1111;
    end else begin
      if (out_valid) begin
        slot_q[outsel]    <= outval;
        written_q[outsel] <= 1'b1;
      end
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign written = written_q;

endmodule

// File: tb/tb_out_display.sv
// Self-checking bench for out_display: a slot/scan model pushes the expected
// {written, an, seg} per edge into exp_q, and each test pops and compares it.
module tb_out_display;

  localparam int SCAN_DIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        out_valid;
  logic [2:0]  outsel;
  logic [15:0] outval;
  logic [2:0]  view_sel;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [7:0]  written;

  out_display #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .out_valid (out_valid),
    .outsel    (outsel),
    .outval    (outval),
    .view_sel  (view_sel),
    .seg       (seg),
    .an        (an),
    .written   (written)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  logic [19:0] got_v, exp_v;

  logic [15:0] m_slot [8];
  logic [7:0]  m_written;
  int          m_cyc;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

`ifdef OUT_DISPLAY_LZB_EN
  localparam logic [7:0] SEG_UPPER_ZERO = 8'hFF;
`else
  localparam logic [7:0] SEG_UPPER_ZERO = 8'hC0;
`endif

  function automatic logic [7:0] exp_seg(input logic [15:0] v, input int d);
    logic [3:0] n;
    n = v[d*4 +: 4];
`ifdef OUT_DISPLAY_LZB_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0000) return 8'hFF;
`endif
    return SEG_TAB[n];
  endfunction

  // Called at the falling edge: drives inputs, predicts the outputs after the
  // next rising edge, then advances the model past that edge.
  task automatic drive_edge(input logic rst, input logic vld, input logic [2:0] sel,
                            input logic [15:0] val, input bit xin);
    int d;
    reset     = rst;
    out_valid = vld;
    if (xin) begin
      outsel = 'x;
      outval = 'x;
    end else begin
      outsel = sel;
      outval = val;
    end
    if (rst) begin
      exp_q.push_back({8'h00, 4'hF, 8'hFF});
    end else begin
      d = (m_cyc / SCAN_DIV) % 4;
      exp_q.push_back({m_written | (vld ? (8'h01 << sel) : 8'h00),
                       ~(4'b0001 << d), exp_seg(m_slot[view_sel], d)});
    end
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_slot[i] = 16'h0000;
      m_written = 8'h00;
      m_cyc     = 0;
    end else begin
      if (vld) begin
        m_slot[sel]    = val;
        m_written[sel] = 1'b1;
      end
      m_cyc++;
    end
    @(negedge clock);
    out_valid = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    view_sel = 3'd0;
    drive_edge(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_state got %h exp %h", got_v, exp_v); end
    for (int i = 0; i < 40; i++) begin
      drive_edge(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
      got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL idle_sb cyc %0d got %h exp %h", i, got_v, exp_v); end
      checks++;
      if (an !== ~(4'b0001 << ((i / 4) % 4)) || seg !== 8'hC0 || written !== 8'h00) begin
        errors++;
        $display("FAIL idle_scan cyc %0d got an %b seg %h wr %h", i, an, seg, written);
      end
    end
  endtask

  task automatic test_capture();
    view_sel = 3'd3;
    drive_edge(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL cap_reset got %h exp %h", got_v, exp_v); end
    drive_edge(1'b0, 1'b1, 3'd3, 16'hA5F1, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL cap_write got %h exp %h", got_v, exp_v); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] want;
      drive_edge(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
      got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL cap_sb cyc %0d got %h exp %h", i, got_v, exp_v); end
      case (an)
        4'b1110: want = 8'hF9;
        4'b1101: want = 8'h8E;
        4'b1011: want = 8'h92;
        4'b0111: want = 8'h88;
        default: want = 8'hxx;
      endcase
      checks++;
      if (seg !== want || written !== 8'h08) begin
        errors++;
        $display("FAIL cap_digit an %b got seg %h wr %h exp seg %h wr 08", an, seg, written, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    view_sel = 3'd0;
    drive_edge(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL b2b_reset got %h exp %h", got_v, exp_v); end
    drive_edge(1'b0, 1'b1, 3'd0, 16'h1234, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL b2b_w1 got %h exp %h", got_v, exp_v); end
    drive_edge(1'b0, 1'b1, 3'd0, 16'hBEEF, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL b2b_w2 got %h exp %h", got_v, exp_v); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] want;
      drive_edge(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
      got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL b2b_sb cyc %0d got %h exp %h", i, got_v, exp_v); end
      case (an)
        4'b1110: want = 8'h8E;
        4'b1101: want = 8'h86;
        4'b1011: want = 8'h86;
        4'b0111: want = 8'h83;
        default: want = 8'hxx;
      endcase
      checks++;
      if (seg !== want || written !== 8'h01) begin
        errors++;
        $display("FAIL b2b_digit an %b got seg %h wr %h exp seg %h wr 01", an, seg, written, want);
      end
    end
  endtask

  task automatic test_write_viewed();
    view_sel = 3'd5;
    drive_edge(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL wv_reset got %h exp %h", got_v, exp_v); end
    // Digit 0 is active for the write edge and the one after it.
    drive_edge(1'b0, 1'b1, 3'd5, 16'h0007, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL wv_sb_write got %h exp %h", got_v, exp_v); end
    checks++;
    if (an !== 4'b1110 || seg !== 8'hC0) begin
      errors++; $display("FAIL wv_write_edge got an %b seg %h exp an 1110 seg c0", an, seg);
    end
    for (int i = 0; i < 15; i++) begin
      logic [7:0] want;
      drive_edge(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
      got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL wv_sb cyc %0d got %h exp %h", i, got_v, exp_v); end
      want = (an == 4'b1110) ? 8'hF8 : SEG_UPPER_ZERO;
      checks++;
      if (seg !== want || (i == 0 && an !== 4'b1110)) begin
        errors++; $display("FAIL wv_digit cyc %0d an %b got seg %h exp %h", i, an, seg, want);
      end
    end
  endtask

  task automatic test_x_inputs();
    for (int i = 0; i < 20; i++) begin
      drive_edge(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
      got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL xin_sb cyc %0d got %h exp %h", i, got_v, exp_v); end
      checks++;
      if ((^{seg, an, written}) === 1'bx || written !== 8'h20) begin
        errors++; $display("FAIL xin_state cyc %0d got seg %h an %b wr %h exp wr 20", i, seg, an, written);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    drive_edge(1'b0, 1'b1, 3'd2, 16'h4321, 1'b0);
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rmw_pre got %h exp %h", got_v, exp_v); end
    drive_edge(1'b1, 1'b1, 3'd6, 16'hFFFF, 1'b0);
    checks++;
    if (an !== 4'b1111 || seg !== 8'hFF || written !== 8'h00) begin
      errors++; $display("FAIL rmw_reset got an %b seg %h wr %h exp 1111 ff 00", an, seg, written);
    end
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rmw_sb_reset got %h exp %h", got_v, exp_v); end
    drive_edge(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++;
    if (an !== 4'b1110 || seg !== 8'hC0 || written !== 8'h00) begin
      errors++; $display("FAIL rmw_after got an %b seg %h wr %h exp 1110 c0 00", an, seg, written);
    end
    got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rmw_sb_after got %h exp %h", got_v, exp_v); end
    for (int v = 0; v < 8; v++) begin
      view_sel = v[2:0];
      for (int i = 0; i < 4; i++) begin
        drive_edge(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
        if (got_v !== exp_v) begin
          errors++; $display("FAIL rmw_cleared view %0d got %h exp %h", v, got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      logic vld;
      vld = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) view_sel = 3'($urandom_range(0, 7));
      drive_edge(1'b0, vld, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), 1'b0);
      got_v = {written, an, seg}; exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL rand_sb cyc %0d got %h exp %h", i, got_v, exp_v); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    out_valid = 1'b0;
    outsel    = 3'd0;
    outval    = 16'h0;
    view_sel  = 3'd0;
    m_written = 8'h00;
    m_cyc     = 0;
    for (int i = 0; i < 8; i++) m_slot[i] = 16'h0000;
    @(negedge clock);

    test_reset();
    test_capture();
    test_back_to_back();
    test_write_viewed();
    test_x_inputs();
    test_reset_mid_write();
    test_random();

    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_display.md
Name: out_display

Overview:
- Output stage directly downstream of the processor's OUT command.
- Captures each OUT result (slot select plus 16-bit value) into an 8-entry slot register file.
- Shows one operator-selected slot as four hex digits on a time-multiplexed, active-low 7-segment display.
- Exposes per-slot "written" flags on LEDs.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range 2..65535.
- NUM_DIGITS, 4: digits scanned; fixed at 4, kept as a parameter only for documentation and checks.

Ports:
- clock  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- out_valid  input  1  one-cycle strobe: an OUT command is committing this cycle.
- outsel  input  3  target slot; sampled only when out_valid=1, may be X otherwise.
- outval  input  16  value to store; sampled only when out_valid=1.
- view_sel  input  3  slot to display (board switches; quasi-static).
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-low.
- an  output  4  digit enables, active-low one-hot; an[0] is the least-significant digit.
- written  output  8  written[i]=1 once slot i has been written since reset.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - All state updates on posedge clock.
  - reset has priority over every other event in the same cycle.
- Reset values:
  - All slots = 16'h0000; written = 8'h00.
  - Scan counter = 0; digit index = 0.
  - seg = 8'hFF; an = 4'b1111.
  - Reset asserted mid-scan or mid-write discards the pending write and restarts the scan at digit 0.
- Capture:
  - Edge where out_valid=1: slot[outsel] <= outval and written[outsel] <= 1.
  - Back-to-back strobes are each taken; no backpressure; the same slot is overwritten.
  - outsel and outval are don't-care when out_valid=0 and must not disturb state, including X values.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0,1,2,3,0.
- Output registers:
  - seg and an are registered.
  - Each cycle: an <= ~(1<<digit), seg <= hex_to_seg(nibble[digit] of slot[view_sel]).
  - So seg/an lag the digit index and slot contents by exactly 1 cycle.
- First cycle after reset deasserts: an = 4'b1110.
- Write-while-viewed: a write to slot[view_sel] at edge N appears on seg at edge N+1 (visible in cycle N+1 to N+2) if that digit is active.
- view_sel change is reflected on the next registered seg update, so no stale digit lingers beyond 1 cycle.
- Segment codes (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - blank=FF
  - dp is always off (bit7=1).
- Sub-module behaviour: hex_to_seg is purely combinational; all timing lives in out_display.

Optional Feature:
- Macro: OUT_DISPLAY_LZB_EN (leading-zero blanking).
- Defined:
  - Digits above the most-significant nonzero nibble output seg=8'hFF.
  - Digit 0 is never blanked, so 16'h0000 shows a single "0".
  - 16'h00A5 blanks digits 3 and 2.
  - an scanning is unchanged.
- Undefined: all four digits always display, including leading zeros.

Decomposition:
- Shared package out_pkg:
  - SEG_BLANK=8'hFF.
  - hex-digit segment constants.
  - OUT_SLOTS=8, OUT_SEL_W=3.
  - digit index typedef (2 bits).
- One sub-module: hex_to_seg (4-bit nibble in, 8-bit active-low segment pattern out); instantiated once on the selected nibble.

Test Plan (SCAN_DIV=4 for simulation):
1. Reset, then idle 40 cycles.
   - written=00 throughout.
   - an sequence 1110,1101,1011,0111, each held 4 cycles.
   - seg=C0 throughout.
2. out_valid=1, outsel=3, outval=16'hA5F1 for one cycle; view_sel=3.
   - written=08.
   - Over one scan: an=1110 with seg=F9, an=1101 with seg=8E, an=1011 with seg=92, an=0111 with seg=88.
3. Back-to-back strobes: slot 0 <= 16'h1234, then slot 0 <= 16'hBEEF on the next cycle; view_sel=0.
   - Final display: digits F,E,E,b giving seg 8E,86,86,83.
   - written=01.
4. Write slot 5 <= 16'h0007 while view_sel=5 and an=1110 is active.
   - seg changes to F8 exactly 1 cycle after the write edge.
   - With OUT_DISPLAY_LZB_EN: digits 1..3 show FF.
   - Without it: digits 1..3 show C0.
5. out_valid=0 with outsel/outval driven X for 20 cycles.
   - No slot or written change; no X on seg or an.
6. reset pulsed for 1 cycle mid-scan on the same cycle as a write strobe.
   - Write dropped; slots and written cleared.
   - an=1111 for that cycle, then 1110 on the next.
